mul_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers for the next-generation pipelined MIPS core, placed in the E stage beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo issued from E and holds a busy window of configurable length.
- Drives a stall request that the hazard controller ORs into its D-stage stall (freeze PC and D register, clear E register).
- HI/LO feed the E-stage mfhi/mflo result path.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mul_div_unit_if.sv | 24 ++
 rtl/mdu_calc.sv | 78 +++++++
 rtl/mul_div_unit.sv | 102 ++++++++++
 tb/tb_mul_div_unit.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared types and sizing for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // Counter must hold the larger of the two latencies.
  function automatic int unsigned cnt_width(input int unsigned m, input int unsigned d);
    return $clog2(((m > d) ? m : d) + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(MULT_CYCLES_DEF, DIV_CYCLES_DEF);

endpackage

// File: rtl/mul_div_unit_if.sv
// E-stage issue bus and HI/LO/stall return path of the multiply/divide unit.
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             d_is_md;
  logic             busy;
  logic             stall_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, d_is_md,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, op, a, b, d_is_md,
    output busy, stall_req, hi, lo
  );
endinterface

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath producing the HI/LO result pair.
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]           a_ext;
  logic [PW-1:0]           b_ext;
  logic [PW-1:0]           prod;
  logic signed [WIDTH-1:0] sa;
  logic signed [WIDTH-1:0] sb;
  logic signed [WIDTH-1:0] sq;
  logic signed [WIDTH-1:0] sr;
  logic [WIDTH-1:0]        uq;
  logic [WIDTH-1:0]        ur;
  logic                    div_zero;
  logic                    div_ovf;

  // Product of sign- or zero-extended operands; quotient/remainder with the special cases.
  always_comb begin
    a_ext    = (op == MD_MULT) ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_ext    = (op == MD_MULT) ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod     = a_ext * b_ext;
    sa       = $signed(a);
    sb       = $signed(b);
    div_zero = (b == '0);
    div_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    sq       = '0;
    sr       = '0;
    uq       = '0;
    ur       = '0;
    res_hi   = '0;
    res_lo   = '0;
    if (!div_zero && !div_ovf) begin
      sq = sa / sb;
      sr = sa % sb;
    end
    if (!div_zero) begin
      uq = a / b;
      ur = a % b;
    end
    case (op)
      MD_MULT, MD_MULTU: {res_hi, res_lo} = prod;
      MD_DIV: begin
        if (div_zero) begin
          res_hi = a;
          res_lo = '1;
        end else if (div_ovf) begin
          res_hi = '0;
          res_lo = a;
        end else begin
          res_hi = sr;
          res_lo = sq;
        end
      end
      MD_DIVU: begin
        if (div_zero) begin
          res_hi = a;
          res_lo = '1;
        end else begin
          res_hi = ur;
          res_lo = uq;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and D-stage stall request.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  mul_div_unit_if.slave bus
);

  localparam int unsigned CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

  mdu_state_e       state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sh_hi, sh_hi_n;
  logic [WIDTH-1:0] sh_lo, sh_lo_n;
  logic [WIDTH-1:0] hi_q, hi_n;
  logic [WIDTH-1:0] lo_q, lo_n;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             busy_q;

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op     (bus.op),
    .a      (bus.a),
    .b      (bus.b),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // State, counter, shadow and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      sh_hi <= '0;
      sh_lo <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sh_hi <= sh_hi_n;
      sh_lo <= sh_lo_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
    end
  end

  // Next-state: capture result at issue, retire into HI/LO on the last busy edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_hi_n = sh_hi;
    sh_lo_n = sh_lo;
    hi_n    = hi_q;
    lo_n    = lo_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            MD_MULT, MD_MULTU: begin
              sh_hi_n = res_hi;
              sh_lo_n = res_lo;
              cnt_n   = CW'(MULT_CYCLES);
              state_n = BUSY;
            end
            MD_DIV, MD_DIVU: begin
              sh_hi_n = res_hi;
              sh_lo_n = res_lo;
              cnt_n   = CW'(DIV_CYCLES);
              state_n = BUSY;
            end
            MD_MTHI: hi_n = bus.a;
            MD_MTLO: lo_n = bus.a;
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          hi_n    = sh_hi;
          lo_n    = sh_lo;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy_q        = (state == BUSY);
  assign bus.busy      = busy_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  // Combinational so the issue cycle of a multi-cycle op already holds D.
  assign bus.stall_req = bus.d_is_md & (busy_q | (bus.start & (bus.op <= 3'(MD_DIVU))));

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: reference model plus directed vectors.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(32)) mif ();

  mul_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of an op computed with wide integer arithmetic.
  function automatic logic [63:0] ref_calc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    longint q;
    longint r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    case (o)
      3'd0: p = 64'(sx * sy);
      3'd1: p = {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = {32'd0, x};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else p = {x % y, x / y};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // Reference model: pending result retires after the op's latency.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_pend = '0;
  int          m_left = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (mif.start) begin
      if (mif.op <= 3'd1) begin
        m_pend <= ref_calc(mif.op, mif.a, mif.b);
        m_left <= 5;
      end else if (mif.op <= 3'd3) begin
        m_pend <= ref_calc(mif.op, mif.a, mif.b);
        m_left <= 10;
      end else if (mif.op == 3'd4) begin
        m_hi <= mif.a;
      end else if (mif.op == 3'd5) begin
        m_lo <= mif.a;
      end
    end
  end

  // Every cycle: DUT outputs against the model.
  logic exp_stall;
  always begin
    @(negedge clk);
    #1;
    exp_stall = mif.d_is_md & ((m_left != 0) | (mif.start & (mif.op <= 3'd3)));
    chk("hi", mif.hi, m_hi);
    chk("lo", mif.lo, m_lo);
    chk("busy", 32'(mif.busy), 32'(m_left != 0));
    chk("stall_req", 32'(mif.stall_req), 32'(exp_stall));
    chk("start_in_busy", 32'(mif.start & mif.busy), 32'd0);
  end

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic dm, input int n,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int bc;
    int sc;
    @(negedge clk);
    mif.start   = 1'b1;
    mif.op      = o;
    mif.a       = av;
    mif.b       = bv;
    mif.d_is_md = dm;
    #1;
    if (dm) chk({name, "_stall_issue"}, 32'(mif.stall_req), 32'(o <= 3'd3));
    @(negedge clk);
    mif.start = 1'b0;
    mif.a     = $urandom;
    mif.b     = $urandom;
    #1;
    bc = 0;
    sc = 0;
    while (mif.busy && bc < 40) begin
      bc++;
      if (mif.stall_req) sc++;
      @(negedge clk);
      #1;
    end
    chk({name, "_busy_len"}, 32'(bc), 32'(n));
    if (dm) begin
      chk({name, "_stall_len"}, 32'(sc), 32'(n));
      chk({name, "_stall_after"}, 32'(mif.stall_req), 32'd0);
    end
    mif.d_is_md = 1'b0;
    chk({name, "_hi"}, mif.hi, ehi);
    chk({name, "_lo"}, mif.lo, elo);
  endtask

  initial begin
    mif.start   = 1'b0;
    mif.op      = 3'd0;
    mif.a       = '0;
    mif.b       = '0;
    mif.d_is_md = 1'b0;

    chk("ref_mult", ref_calc(3'd0, 32'hFFFF_FFFE, 32'd3) >> 32, 32'hFFFF_FFFF);
    chk("ref_multu_lo", 32'(ref_calc(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 32'h0000_0001);
    chk("ref_div_lo", 32'(ref_calc(3'd2, 32'hFFFF_FFF9, 32'd2)), 32'hFFFF_FFFD);
    chk("ref_divu_hi", ref_calc(3'd3, 32'd7, 32'd0) >> 32, 32'd7);

    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", 32'(mif.busy), 32'd0);
    chk("reset_hi", mif.hi, 32'd0);
    chk("reset_lo", mif.lo, 32'd0);
    reset = 1'b1;

    run_op("mult",     3'd0, 32'hFFFF_FFFE, 32'd3,        1'b0, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5,  32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div",      3'd2, 32'hFFFF_FFF9, 32'd2,        1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_z",   3'd3, 32'd7,         32'd0,        1'b0, 10, 32'd7,         32'hFFFF_FFFF);
    run_op("div_ovf",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 32'd0,        32'h8000_0000);
    run_op("div_z",    3'd2, 32'hFFFF_FFFB, 32'd0,        1'b0, 10, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("div_negb", 3'd2, 32'd7,         32'hFFFF_FFFE, 1'b0, 10, 32'd1,        32'hFFFF_FFFD);
    run_op("div_stall",3'd2, 32'd100,       32'd7,        1'b1, 10, 32'd2,         32'd14);
    run_op("mthi",     3'd4, 32'h1234_5678, 32'd0,        1'b0, 0,  32'h1234_5678, 32'd14);
    run_op("mtlo",     3'd5, 32'hCAFE_F00D, 32'd0,        1'b1, 0,  32'h1234_5678, 32'hCAFE_F00D);
    run_op("nop",      3'd6, 32'hDEAD_BEEF, 32'd1,        1'b0, 0,  32'h1234_5678, 32'hCAFE_F00D);

    // Reset in the middle of a multiply.
    @(negedge clk);
    mif.start = 1'b1;
    mif.op    = 3'd0;
    mif.a     = 32'd3;
    mif.b     = 32'd4;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("midrst_busy_before", 32'(mif.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(mif.busy), 32'd0);
    chk("midrst_hi", mif.hi, 32'd0);
    chk("midrst_lo", mif.lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("postrst_busy", 32'(mif.busy), 32'd0);
    chk("postrst_hi", mif.hi, 32'd0);
    chk("postrst_lo", mif.lo, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
